// File: rtl/mcmc_pkg.sv
// Shared definitions for the Metropolis commit controller and its helpers.
package mcmc_pkg;
  localparam int COST_WIDTH = 7;
  localparam int PROB_WIDTH = 8;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL,
    ST_DECIDE,
    ST_DONE
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction
endpackage

// File: rtl/metropolis_best_tracker.sv
// Best-so-far register pair: reloads on start, improves only on a strictly lower accepted cost.
module metropolis_best_tracker
  import mcmc_pkg::*;
#(
  parameter int VAR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VAR_WIDTH-1:0]  init_assignment,
  input  logic [COST_WIDTH-1:0] init_cost,
  input  logic                  update,
  input  logic [VAR_WIDTH-1:0]  prop_assignment,
  input  logic [COST_WIDTH-1:0] prop_cost,
  output logic [VAR_WIDTH-1:0]  best_assignment,
  output logic [COST_WIDTH-1:0] best_cost
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_assignment <= '0;
      best_cost       <= '0;
    end else if (load) begin
      best_assignment <= init_assignment;
      best_cost       <= init_cost;
    end else if (update && (prop_cost < best_cost)) begin
      // ties keep the older best
      best_assignment <= prop_assignment;
      best_cost       <= prop_cost;
    end
  end

endmodule

// File: rtl/metropolis_commit_ctrl.sv
// Metropolis proposal/commit sequencer: handshake, probability-unit strobe, accept/commit, stop rules.
module metropolis_commit_ctrl
  import mcmc_pkg::*;
#(
  parameter int          VAR_WIDTH = 32,
  parameter logic [15:0] MAX_ITER  = 16'd1000
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_start,
  input  logic [VAR_WIDTH-1:0]  in_init_assignment,
  input  logic [COST_WIDTH-1:0] in_init_cost,
  input  logic                  in_prop_valid,
  output logic                  out_prop_ready,
  input  logic [VAR_WIDTH-1:0]  in_prop_assignment,
  input  logic [COST_WIDTH-1:0] in_prop_cost,
  output logic [PROB_WIDTH-1:0] out_u,
  output logic [PROB_WIDTH-1:0] out_v,
  output logic                  out_rng_enable,
  input  logic                  in_accept,
  output logic [VAR_WIDTH-1:0]  out_cur_assignment,
  output logic [COST_WIDTH-1:0] out_cur_cost,
  output logic [VAR_WIDTH-1:0]  out_best_assignment,
  output logic [COST_WIDTH-1:0] out_best_cost,
  output logic                  out_commit,
  output logic [CNT_WIDTH-1:0]  out_iter_count,
  output logic [CNT_WIDTH-1:0]  out_accept_count,
  output logic                  out_done
);

  state_t state, state_nxt;

  logic [VAR_WIDTH-1:0]  prop_assignment_p0;
  logic [COST_WIDTH-1:0] prop_cost_p0;

  logic                  handshake;
  logic                  decide;
  logic                  take;
  logic [COST_WIDTH-1:0] new_cost;
  logic [CNT_WIDTH-1:0]  iter_nxt;

  // in_start pre-empts everything, so an in-flight proposal never commits or counts
  assign handshake = (state == ST_WAIT) && in_prop_valid && !in_start;
  assign decide    = (state == ST_DECIDE) && !in_start;
  assign take      = decide && in_accept;
  assign new_cost  = take ? prop_cost_p0 : out_cur_cost;
  assign iter_nxt  = sat_inc(out_iter_count);

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    out_prop_ready = 1'b0;
    out_rng_enable = 1'b0;
    out_done       = 1'b0;
    case (state)
      ST_IDLE:   state_nxt = ST_IDLE;
      ST_WAIT: begin
        out_prop_ready = 1'b1;
        if (in_prop_valid) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        out_rng_enable = 1'b1;
        state_nxt      = ST_DECIDE;
      end
      ST_DECIDE: begin
        if ((new_cost == '0) || (iter_nxt >= MAX_ITER)) state_nxt = ST_DONE;
        else                                            state_nxt = ST_WAIT;
      end
      ST_DONE: begin
        out_done  = 1'b1;
        state_nxt = ST_DONE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    if (in_start) state_nxt = (in_init_cost == '0) ? ST_DONE : ST_WAIT;
  end

  // p0: proposal capture at the handshake edge
  always_ff @(posedge in_clock) begin
    if (handshake) begin
      prop_assignment_p0 <= in_prop_assignment;
      prop_cost_p0       <= in_prop_cost;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      out_cur_assignment <= '0;
      out_cur_cost       <= '0;
      out_iter_count     <= '0;
      out_accept_count   <= '0;
      out_commit         <= 1'b0;
      out_u              <= '0;
      out_v              <= '0;
    end else begin
      out_commit <= take;
      if (in_start) begin
        out_cur_assignment <= in_init_assignment;
        out_cur_cost       <= in_init_cost;
        out_iter_count     <= '0;
        out_accept_count   <= '0;
      end else begin
        if (handshake) begin
          out_u <= {{(PROB_WIDTH-COST_WIDTH){1'b0}}, out_cur_cost};
          out_v <= {{(PROB_WIDTH-COST_WIDTH){1'b0}}, in_prop_cost};
        end
        if (decide) out_iter_count <= iter_nxt;
        if (take) begin
          out_cur_assignment <= prop_assignment_p0;
          out_cur_cost       <= prop_cost_p0;
          out_accept_count   <= sat_inc(out_accept_count);
        end
      end
    end
  end

  metropolis_best_tracker #(
    .VAR_WIDTH(VAR_WIDTH)
  ) u_best (
    .clk             (in_clock),
    .rst             (in_reset),
    .load            (in_start),
    .init_assignment (in_init_assignment),
    .init_cost       (in_init_cost),
    .update          (take),
    .prop_assignment (prop_assignment_p0),
    .prop_cost       (prop_cost_p0),
    .best_assignment (out_best_assignment),
    .best_cost       (out_best_cost)
  );

endmodule

// File: tb/tb_metropolis_commit_ctrl.sv
// Randomized bench for metropolis_commit_ctrl against a transaction-level Metropolis model.
module tb_metropolis_commit_ctrl;
  localparam int          VW = 32;
  localparam logic [15:0] MI = 16'd3;

  logic          in_clock, in_reset, in_start;
  logic [VW-1:0] in_init_assignment, in_prop_assignment;
  logic [6:0]    in_init_cost, in_prop_cost;
  logic          in_prop_valid, out_prop_ready, out_rng_enable, in_accept;
  logic [7:0]    out_u, out_v;
  logic [VW-1:0] out_cur_assignment, out_best_assignment;
  logic [6:0]    out_cur_cost, out_best_cost;
  logic          out_commit, out_done;
  logic [15:0]   out_iter_count, out_accept_count;

  metropolis_commit_ctrl #(.VAR_WIDTH(VW), .MAX_ITER(MI)) dut (
    .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start),
    .in_init_assignment(in_init_assignment), .in_init_cost(in_init_cost),
    .in_prop_valid(in_prop_valid), .out_prop_ready(out_prop_ready),
    .in_prop_assignment(in_prop_assignment), .in_prop_cost(in_prop_cost),
    .out_u(out_u), .out_v(out_v), .out_rng_enable(out_rng_enable), .in_accept(in_accept),
    .out_cur_assignment(out_cur_assignment), .out_cur_cost(out_cur_cost),
    .out_best_assignment(out_best_assignment), .out_best_cost(out_best_cost),
    .out_commit(out_commit), .out_iter_count(out_iter_count),
    .out_accept_count(out_accept_count), .out_done(out_done)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [VW-1:0] m_cur_a, m_best_a;
  int            m_cur_c, m_best_c, m_iter, m_acc;
  bit            m_done;

  logic [6:0]    rc;
  logic          racc;
  int            rab, k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_load(input logic [VW-1:0] a, input logic [6:0] c);
    m_cur_a = a;  m_cur_c = int'(c);
    m_best_a = a; m_best_c = int'(c);
    m_iter = 0;   m_acc = 0;
    m_done = (c == 0);
  endtask

  task automatic model_step(input logic [VW-1:0] a, input logic [6:0] c, input logic acc);
    if (m_iter < 65535) m_iter++;
    if (acc) begin
      if (m_acc < 65535) m_acc++;
      if (int'(c) < m_best_c) begin
        m_best_a = a; m_best_c = int'(c);
      end
      m_cur_a = a; m_cur_c = int'(c);
    end
    m_done = (m_cur_c == 0) || (m_iter >= int'(MI));
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".cur_a"},  out_cur_assignment,  m_cur_a);
    chk({tag, ".cur_c"},  32'(out_cur_cost),   32'(m_cur_c));
    chk({tag, ".best_a"}, out_best_assignment, m_best_a);
    chk({tag, ".best_c"}, 32'(out_best_cost),  32'(m_best_c));
    chk({tag, ".iter"},   32'(out_iter_count), 32'(m_iter));
    chk({tag, ".acc"},    32'(out_accept_count), 32'(m_acc));
    chk({tag, ".done"},   32'(out_done),       32'(m_done));
    chk({tag, ".ready"},  32'(out_prop_ready), 32'(!m_done));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cur_a"},  out_cur_assignment,  0);
    chk({tag, ".cur_c"},  32'(out_cur_cost),   0);
    chk({tag, ".best_a"}, out_best_assignment, 0);
    chk({tag, ".best_c"}, 32'(out_best_cost),  0);
    chk({tag, ".iter"},   32'(out_iter_count), 0);
    chk({tag, ".acc"},    32'(out_accept_count), 0);
    chk({tag, ".commit"}, 32'(out_commit),     0);
    chk({tag, ".done"},   32'(out_done),       0);
    chk({tag, ".rng"},    32'(out_rng_enable), 0);
    chk({tag, ".u"},      32'(out_u),          0);
    chk({tag, ".v"},      32'(out_v),          0);
    chk({tag, ".ready"},  32'(out_prop_ready), 0);
  endtask

  task automatic start_run(input logic [VW-1:0] a, input logic [6:0] c);
    in_start = 1'b1; in_init_assignment = a; in_init_cost = c; in_prop_valid = 1'b0;
    @(posedge in_clock); @(negedge in_clock);
    in_start = 1'b0; in_init_assignment = $urandom; in_init_cost = 7'($urandom);
    model_load(a, c);
    chk("start.commit", 32'(out_commit), 0);
    check_state("start");
  endtask

  // abort: 0 none, 1 restart during EVAL, 2 restart during DECIDE
  task automatic propose(input logic [VW-1:0] a, input logic [6:0] c, input logic acc, input int abort);
    chk("wait.ready", 32'(out_prop_ready), 1);
    in_prop_valid = 1'b1; in_prop_assignment = a; in_prop_cost = c; in_accept = acc;
    @(posedge in_clock); @(negedge in_clock);
    in_prop_valid = 1'b0; in_prop_assignment = $urandom; in_prop_cost = 7'($urandom);
    chk("eval.ready",  32'(out_prop_ready), 0);
    chk("eval.rng",    32'(out_rng_enable), 1);
    chk("eval.u",      32'(out_u), 32'(m_cur_c));
    chk("eval.v",      32'(out_v), 32'(c));
    chk("eval.commit", 32'(out_commit), 0);
    if (abort == 1) begin
      start_run($urandom, 7'($urandom_range(1, 127)));
      return;
    end
    @(posedge in_clock); @(negedge in_clock);
    chk("dec.rng",    32'(out_rng_enable), 0);
    chk("dec.u",      32'(out_u), 32'(m_cur_c));
    chk("dec.v",      32'(out_v), 32'(c));
    chk("dec.ready",  32'(out_prop_ready), 0);
    chk("dec.commit", 32'(out_commit), 0);
    if (abort == 2) begin
      start_run($urandom, 7'($urandom_range(1, 127)));
      return;
    end
    @(posedge in_clock); @(negedge in_clock);
    in_accept = ~acc;
    model_step(a, c, acc);
    chk("commit", 32'(out_commit), 32'(acc));
    check_state("post");
  endtask

  task automatic done_probe();
    chk("done.flag",  32'(out_done), 1);
    chk("done.ready", 32'(out_prop_ready), 0);
    in_prop_valid = 1'b1; in_prop_cost = 7'd0; in_accept = 1'b1;
    repeat (3) @(negedge in_clock);
    in_prop_valid = 1'b0;
    chk("done.commit", 32'(out_commit), 0);
    check_state("done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    in_reset = 1'b1; in_start = 1'b0; in_prop_valid = 1'b0; in_accept = 1'b0;
    in_init_assignment = '0; in_init_cost = '0; in_prop_assignment = '0; in_prop_cost = '0;
    repeat (2) @(negedge in_clock);
    chk_all_zero("reset");
    in_reset = 1'b0;
    // valid in IDLE must be ignored
    in_prop_valid = 1'b1;
    repeat (2) @(negedge in_clock);
    in_prop_valid = 1'b0;
    chk("idle.ready", 32'(out_prop_ready), 0);
    chk("idle.iter",  32'(out_iter_count), 0);

    // reset while in EVAL
    start_run(32'hA5A5_0001, 7'd20);
    in_prop_valid = 1'b1; in_prop_assignment = 32'h1234; in_prop_cost = 7'd7; in_accept = 1'b1;
    @(posedge in_clock); @(negedge in_clock);
    in_prop_valid = 1'b0;
    chk("rst_eval.pre_rng", 32'(out_rng_enable), 1);
    in_reset = 1'b1;
    #1;
    chk_all_zero("rst_eval");
    @(negedge in_clock);
    in_reset = 1'b0;
    repeat (3) @(negedge in_clock);
    chk("rst_eval.idle_ready",  32'(out_prop_ready), 0);
    chk("rst_eval.idle_commit", 32'(out_commit), 0);
    chk("rst_eval.idle_done",   32'(out_done), 0);

    // cost 5 -> accepted cost 3
    start_run(32'h0000_0005, 7'd5);
    propose(32'h0000_0003, 7'd3, 1'b1, 0);
    chk("d35.cur_c",  32'(out_cur_cost), 3);
    chk("d35.best_c", 32'(out_best_cost), 3);
    chk("d35.acc",    32'(out_accept_count), 1);

    // cost 3 -> rejected cost 6
    start_run(32'h0000_0033, 7'd3);
    propose(32'h0000_0066, 7'd6, 1'b0, 0);
    chk("d36.cur_c", 32'(out_cur_cost), 3);
    chk("d36.iter",  32'(out_iter_count), 1);
    chk("d36.ready", 32'(out_prop_ready), 1);

    // tie: current moves, best stays
    start_run(32'hBEEF_0004, 7'd4);
    propose(32'hCAFE_0004, 7'd4, 1'b1, 0);
    chk("d37.cur_a",  out_cur_assignment,  32'hCAFE_0004);
    chk("d37.best_a", out_best_assignment, 32'hBEEF_0004);

    // accepted zero cost stops the run
    start_run(32'h9, 7'd9);
    propose(32'h0, 7'd0, 1'b1, 0);
    done_probe();
    start_run(32'h11, 7'd11);
    chk("d38.restart_ready", 32'(out_prop_ready), 1);

    // iteration budget, then restart during DECIDE
    start_run(32'h50, 7'd50);
    for (int i = 0; i < 3; i++) propose($urandom, 7'($urandom_range(60, 127)), 1'b0, 0);
    done_probe();
    start_run(32'h51, 7'd51);
    propose(32'h2, 7'd2, 1'b1, 0);
    propose(32'h1, 7'd1, 1'b1, 2);
    chk("d39.iter", 32'(out_iter_count), 0);
    chk("d39.acc",  32'(out_accept_count), 0);

    // start with zero cost goes straight to DONE
    start_run(32'h77, 7'd0);
    done_probe();

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      rc = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      start_run($urandom, rc);
      k = 0;
      while (!m_done && k < 6) begin
        case ($urandom_range(0, 5))
          0:       rc = 7'd0;
          1:       rc = 7'(m_cur_c);
          default: rc = 7'($urandom);
        endcase
        racc = 1'($urandom);
        rab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
        propose($urandom, rc, racc, rab);
        k++;
      end
      if (m_done) done_probe();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
